// File: rtl/sample_capture_writer.sv
// Packs a 16-bit sample stream into 32-bit on-chip memory words, one capture per start.
// Build option: define CAPTURE_WRAP_EN for circular capture that runs until stop.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; length sampled and clamped on start
// S_CAPTURE | accepting samples, writing each completed pair
// S_FLUSH   | writing the pending lower half-word after an early stop
// S_DONE    | single-cycle completion; done pulses here
module sample_capture_writer #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   length,
  input  logic              snk_valid,
  input  logic [15:0]       snk_data,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_half_valid;
  logic [15:0]       r_half_data;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic [ADDR_W-1:0] r_mem_address;
  logic [3:0]        r_mem_byteenable;
  logic              r_mem_write;
  logic [31:0]       r_mem_writedata;

  logic              w_ready;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_pair_done;
  logic              w_half_after;
  logic              w_at_last;
  logic              w_final_word;
  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W:0]   w_last_index;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W:0]   w_words_next;

  assign w_ready       = (r_state == S_CAPTURE);
  assign w_accept      = snk_valid & w_ready;
  assign w_start_ok    = start & (r_state == S_IDLE);
  assign w_pair_done   = w_accept & r_half_valid;
  // Half-word still pending once this cycle's sample (if any) has been taken.
  assign w_half_after  = r_half_valid ^ w_accept;
  assign w_len_clamped = (length > DEPTH_W) ? DEPTH_W : length;
  assign w_last_index  = r_len - ONE_W;
  assign w_at_last     = ({1'b0, r_addr} == w_last_index);

`ifdef CAPTURE_WRAP_EN
  assign w_final_word  = 1'b0;
  assign w_addr_next   = w_at_last ? '0 : (r_addr + ONE_A);
  assign w_words_next  = (r_words == r_len) ? r_words : (r_words + ONE_W);
`else
  assign w_final_word  = w_pair_done & w_at_last;
  assign w_addr_next   = r_addr + ONE_A;
  assign w_words_next  = r_words + ONE_W;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    snk_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        snk_ready = 1'b1;
        if (w_final_word) begin
          w_state_nxt = S_DONE;
        end else if (stop) begin
          w_state_nxt = w_half_after ? S_FLUSH : S_DONE;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len            <= '0;
      r_addr           <= '0;
      r_words          <= '0;
      r_half_valid     <= 1'b0;
      r_half_data      <= '0;
      r_overflow       <= 1'b0;
      r_drop_count     <= '0;
      r_mem_address    <= '0;
      r_mem_byteenable <= '0;
      r_mem_write      <= 1'b0;
      r_mem_writedata  <= '0;
    end else begin
      r_mem_write <= 1'b0;

      // A start clears the drop statistics even if a drop coincides with it.
      if (w_start_ok) begin
        r_len        <= w_len_clamped;
        r_addr       <= '0;
        r_words      <= '0;
        r_half_valid <= 1'b0;
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else if (snk_valid && !w_ready) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end

      if (w_accept && !r_half_valid) begin
        r_half_valid <= 1'b1;
        r_half_data  <= snk_data;
      end

      if (w_pair_done) begin
        r_half_valid     <= 1'b0;
        r_mem_write      <= 1'b1;
        r_mem_address    <= r_addr;
        r_mem_byteenable <= 4'hF;
        r_mem_writedata  <= {snk_data, r_half_data};
        r_addr           <= w_addr_next;
        r_words          <= w_words_next;
      end

      if (r_state == S_FLUSH) begin
        r_half_valid     <= 1'b0;
        r_mem_write      <= 1'b1;
        r_mem_address    <= r_addr;
        r_mem_byteenable <= 4'b0011;
        r_mem_writedata  <= {16'h0000, r_half_data};
        r_addr           <= w_addr_next;
        r_words          <= w_words_next;
      end
    end
  end

  assign mem_address    = r_mem_address;
  assign mem_byteenable = r_mem_byteenable;
  assign mem_chipselect = r_mem_write;
  assign mem_write      = r_mem_write;
  assign mem_writedata  = r_mem_writedata;
  assign mem_clken      = 1'b1;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;
  assign words_written  = r_words;

endmodule
